// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory for the MIPS32 fetch stage.
// A streaming loader fills the RAM in LOAD; in RUN the fetch path reads it with
// one cycle of latency and reports misaligned or unloaded addresses.
module instr_mem_loadable #(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_done,
    output logic                  load_ready,
    input  logic                  fetch_en,
    input  logic                  stall,
    input  logic [31:0]           pc,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    output logic                  fault_misalign,
    output logic                  fault_range,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;
    logic                  load_ready_q, load_ready_d;
    // sel_mem_q: the presented result comes from the RAM read register
    logic                  sel_mem_q, sel_mem_d;
    logic                  valid_q, valid_d;
    logic                  mis_q, mis_d;
    logic                  rng_q, rng_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  accept;
    logic                  fetch_live;
    logic                  misalign;
    logic                  out_range;
    logic                  ram_re;

    assign idx = pc[ADDR_WIDTH+1:2];

    // Loader state machine: next state, write pointer, program length, ready flag
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        words_d  = words_q;
        accept   = (state_q == ST_LOAD) && load_valid && load_ready_q;
        case (state_q)
            ST_BOOT: begin
                if (load_start) begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = '0;
                    words_d  = '0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + (ADDR_WIDTH+1)'(1);
                end
                // A word accepted alongside load_done is part of the program.
                if (load_done) begin
                    state_d = ST_RUN;
                    words_d = wr_ptr_d;
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = '0;
                    words_d  = '0;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
        // The MSB of the pointer is set exactly when it has reached DEPTH, so
        // the memory is full and further words are dropped rather than wrapped.
        load_ready_d = (state_d == ST_LOAD) && !wr_ptr_d[ADDR_WIDTH];
    end

    // Fetch path: classify the request and decide the next presented result
    always_comb begin
        // Fetching is only live while staying in RUN; leaving RUN (reload)
        // clears the pipeline even when stall is high.
        fetch_live = (state_q == ST_RUN) && (state_d == ST_RUN);
        misalign   = |pc[1:0];
        out_range  = (|pc[31:ADDR_WIDTH+2]) || ({1'b0, idx} >= words_q);
        sel_mem_d  = sel_mem_q;
        valid_d    = valid_q;
        mis_d      = mis_q;
        rng_d      = rng_q;
        ram_re     = 1'b0;
        if (!fetch_live) begin
            sel_mem_d = 1'b0;
            valid_d   = 1'b0;
            mis_d     = 1'b0;
            rng_d     = 1'b0;
        end else if (!stall) begin
            sel_mem_d = 1'b0;
            valid_d   = fetch_en;
            mis_d     = 1'b0;
            rng_d     = 1'b0;
            if (fetch_en) begin
                if (misalign) begin
                    mis_d = 1'b1;
                end else if (out_range) begin
                    rng_d = 1'b1;
                end else begin
                    sel_mem_d = 1'b1;
                    ram_re    = 1'b1;
                end
            end
        end
        // Single address port: the loader and the fetch path never share a state.
        ram_addr = (state_q == ST_LOAD) ? wr_ptr_q[ADDR_WIDTH-1:0] : idx;
    end

    // Control and output flags, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_BOOT;
            wr_ptr_q     <= '0;
            words_q      <= '0;
            load_ready_q <= 1'b0;
            sel_mem_q    <= 1'b0;
            valid_q      <= 1'b0;
            mis_q        <= 1'b0;
            rng_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            words_q      <= words_d;
            load_ready_q <= load_ready_d;
            sel_mem_q    <= sel_mem_d;
            valid_q      <= valid_d;
            mis_q        <= mis_d;
            rng_q        <= rng_d;
        end
    end

    // Program RAM: synchronous write from the loader, registered read for fetch.
    // The read register only updates on an accepted in-range fetch, so it holds
    // its word across stalls; contents are never cleared by reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[ram_addr] <= load_data;
        end
        if (ram_re) begin
            rdata_q <= mem[ram_addr];
        end
    end

    assign instr          = sel_mem_q ? rdata_q : NOP_WORD;
    assign instr_valid    = valid_q;
    assign fault_misalign = mis_q;
    assign fault_range    = rng_q;
    assign load_ready     = load_ready_q;
    assign words_loaded   = words_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed plus randomized bench for instr_mem_loadable; a cycle-level
// behavioural model predicts every output after every clock edge.
module tb_instr_mem_loadable;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data  = '0;
    logic        load_done  = 1'b0;
    logic        fetch_en   = 1'b0;
    logic        stall      = 1'b0;
    logic [31:0] pc         = '0;
    logic        load_ready;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fault_misalign;
    logic        fault_range;
    logic [AW:0] words_loaded;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: 0 = boot, 1 = loading, 2 = running
    int          m_mode  = 0;
    int unsigned m_wr    = 0;
    int unsigned m_words = 0;
    bit          m_ready = 1'b0;
    logic [31:0] m_mem [DEPTH];
    logic [31:0] e_instr = '0;
    bit          e_valid = 1'b0;
    bit          e_mis   = 1'b0;
    bit          e_rng   = 1'b0;
    logic [31:0] first_word;
    logic [31:0] last_word;

    instr_mem_loadable #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .NOP_WORD(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .load_start     (load_start),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .load_done      (load_done),
        .load_ready     (load_ready),
        .fetch_en       (fetch_en),
        .stall          (stall),
        .pc             (pc),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .fault_misalign (fault_misalign),
        .fault_range    (fault_range),
        .words_loaded   (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_out();
        e_instr = 32'h0;
        e_valid = 1'b0;
        e_mis   = 1'b0;
        e_rng   = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        if (!reset) begin
            m_mode  = 0;
            m_wr    = 0;
            m_words = 0;
            clear_out();
        end else if (m_mode == 0) begin
            clear_out();
            if (load_start) begin
                m_mode  = 1;
                m_wr    = 0;
                m_words = 0;
            end
        end else if (m_mode == 1) begin
            clear_out();
            if (load_valid && m_wr < DEPTH) begin
                m_mem[m_wr] = load_data;
                m_wr = m_wr + 1;
            end
            if (load_done) begin
                m_words = m_wr;
                m_mode  = 2;
            end
        end else begin
            if (load_start) begin
                m_mode  = 1;
                m_wr    = 0;
                m_words = 0;
                clear_out();
            end else if (!stall) begin
                clear_out();
                if (fetch_en) begin
                    e_valid = 1'b1;
                    if (pc % 4 != 0)            e_mis   = 1'b1;
                    else if (pc / 4 >= m_words) e_rng   = 1'b1;
                    else                        e_instr = m_mem[pc / 4];
                end
            end
        end
        m_ready = (m_mode == 1) && (m_wr < DEPTH);
    endtask

    task automatic check_all(input string tag);
        check({tag, "/instr"}, 64'(instr), 64'(e_instr));
        check({tag, "/valid"}, 64'(instr_valid), 64'(e_valid));
        check({tag, "/mis"}, 64'(fault_misalign), 64'(e_mis));
        check({tag, "/rng"}, 64'(fault_range), 64'(e_rng));
        check({tag, "/ready"}, 64'(load_ready), 64'(m_ready));
        check({tag, "/words"}, 64'(words_loaded), 64'(m_words));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick("start");
        load_start = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] d, input logic done);
        load_valid = 1'b1;
        load_data  = d;
        load_done  = done;
        tick("load");
        load_valid = 1'b0;
        load_done  = 1'b0;
    endtask

    task automatic finish_load();
        load_done = 1'b1;
        tick("done");
        load_done = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr, input string tag);
        fetch_en = 1'b1;
        stall    = 1'b0;
        pc       = addr;
        tick(tag);
    endtask

    task automatic random_fetches(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            int unsigned r;
            r        = $urandom_range(0, 9);
            fetch_en = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            if (r < 6)      pc = 32'($urandom_range(0, m_words + 2)) << 2;
            else if (r < 8) pc = (32'($urandom_range(0, 40)) << 2) | 32'($urandom_range(1, 3));
            else            pc = $urandom;
            tick(tag);
        end
        stall    = 1'b0;
        fetch_en = 1'b0;
    endtask

    initial begin
        // Reset state
        reset = 1'b0;
        tick("reset");
        tick("reset");
        check("rst_instr", 64'(instr), 64'h0);
        check("rst_valid", 64'(instr_valid), 64'h0);
        check("rst_ready", 64'(load_ready), 64'h0);
        check("rst_words", 64'(words_loaded), 64'h0);
        reset = 1'b1;
        // Fetches are ignored in BOOT
        fetch(32'h0, "boot_fetch");
        check("boot_valid", 64'(instr_valid), 64'h0);
        fetch_en = 1'b0;

        // Test 1: load four words, fetch them back
        start_load();
        check("t1_ready", 64'(load_ready), 64'h1);
        load_word(32'h20080005, 1'b0);
        load_word(32'h20090007, 1'b0);
        load_word(32'h01095020, 1'b0);
        load_word(32'hAC0A0000, 1'b0);
        finish_load();
        check("t1_words", 64'(words_loaded), 64'd4);
        check("t1_ready_run", 64'(load_ready), 64'h0);
        fetch(32'd0, "t1_pc0");
        check("t1_w0", 64'(instr), 64'h20080005);
        fetch(32'd4, "t1_pc4");
        check("t1_w1", 64'(instr), 64'h20090007);
        fetch(32'd8, "t1_pc8");
        check("t1_w2", 64'(instr), 64'h01095020);
        fetch(32'd12, "t1_pc12");
        check("t1_w3", 64'(instr), 64'hAC0A0000);

        // Test 2: range and alignment faults
        fetch(32'd16, "t2_pc16");
        check("t2_rng16", 64'({instr_valid, fault_range, fault_misalign}), 64'b110);
        fetch(32'h00001000, "t2_high");
        check("t2_rng_high", 64'(fault_range), 64'h1);
        fetch(32'd6, "t2_pc6");
        check("t2_mis6", 64'({fault_misalign, fault_range}), 64'b10);

        // Test 3: stall holds the output
        fetch(32'd4, "t3_pc4");
        stall = 1'b1;
        pc    = 32'd8;
        for (int i = 0; i < 3; i++) begin
            tick("t3_stall");
            check("t3_hold", 64'(instr), 64'h20090007);
        end
        fetch(32'd8, "t3_release");
        check("t3_after", 64'(instr), 64'h01095020);
        fetch_en = 1'b0;
        tick("t3_idle");
        check("t3_idle_valid", 64'(instr_valid), 64'h0);

        // Randomized fetches against the four-word program
        random_fetches(60, "rnd4");

        // Test 5: reset in the middle of a reload
        start_load();
        load_word(32'h11111111, 1'b0);
        load_word(32'h22222222, 1'b0);
        reset = 1'b0;
        tick("t5_reset");
        reset = 1'b1;
        check("t5_words", 64'(words_loaded), 64'h0);
        check("t5_ready", 64'(load_ready), 64'h0);
        fetch(32'd0, "t5_boot_fetch");
        check("t5_valid", 64'(instr_valid), 64'h0);
        start_load();
        fetch_en = 1'b1;
        load_word(32'h33333333, 1'b0);
        check("t5_load_valid", 64'(instr_valid), 64'h0);
        finish_load();
        fetch(32'd0, "t5_new");
        check("t5_new_word", 64'(instr), 64'h33333333);

        // Test 6: reload from RUN, one word with load_done in the same cycle
        fetch_en = 1'b0;
        start_load();
        load_word(32'h00000020, 1'b1);
        check("t6_words", 64'(words_loaded), 64'd1);
        fetch(32'd0, "t6_pc0");
        check("t6_w0", 64'(instr), 64'h00000020);
        fetch(32'd4, "t6_pc4");
        check("t6_rng", 64'(fault_range), 64'h1);
        fetch_en = 1'b0;

        // Test 4: fill to DEPTH, one extra word must be dropped without wrap
        start_load();
        first_word = $urandom;
        last_word  = first_word;
        for (int i = 0; i < DEPTH + 1; i++) begin
            logic [31:0] d;
            d = (i == 0) ? first_word : $urandom;
            if (i == DEPTH - 1) last_word = d;
            load_valid = 1'b1;
            load_data  = d;
            tick("t4_fill");
            if (i == DEPTH - 1) check("t4_ready_drop", 64'(load_ready), 64'h0);
        end
        load_valid = 1'b0;
        finish_load();
        check("t4_words", 64'(words_loaded), 64'(DEPTH));
        fetch(32'd0, "t4_pc0");
        check("t4_no_wrap", 64'(instr), 64'(first_word));
        fetch(32'((DEPTH - 1) * 4), "t4_last");
        check("t4_last_word", 64'(instr), 64'(last_word));
        fetch(32'(DEPTH * 4), "t4_beyond");
        check("t4_beyond_rng", 64'(fault_range), 64'h1);
        random_fetches(80, "rndfull");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
